// File: rtl/conv_feeder.sv
// Purpose : loads one K-tap weight vector and one N-sample fmap line, then streams
//           one (fmap, weight) pair per clock plus worken/outputen/acc_valid for the MAC.
// Latency : RUN starts the cycle after the last load word; one window per K cycles;
//           acc_valid trails each outputen by one cycle.
// Backpr. : none while streaming; load accepts a word on in_valid & in_ready and
//           tolerates bubbles of any length.
//
// Ports:
//   clk, rst           - rising-edge clock, synchronous active-high reset
//   start              - begins load+run, sampled only in IDLE
//   in_valid/in_data   - load stream: K weights (tap 0 first), then N fmap samples
//   in_ready           - high while loading
//   data_fmaps/weight  - signed MAC operands
//   worken/outputen    - MAC accumulate enable / dump-and-restart strobe
//   acc_valid/win_idx  - MAC acc holds window win_idx this cycle
//   busy/done          - busy in LOAD/RUN/FLUSH, done during DRAIN
//
// Optional feature: define CONV_FEEDER_PAD_EN for same-size output with
// (K-1)/2 zero padding on each side (N windows instead of N-K+1).

module conv_feeder #(
  parameter int K  = 3,
  parameter int N  = 32,
  parameter int DW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    in_data,
  output logic                    in_ready,
  output logic signed [DW-1:0]    data_fmaps,
  output logic signed [DW-1:0]    data_weight,
  output logic                    worken,
  output logic                    outputen,
  output logic                    acc_valid,
  output logic [$clog2(N+1)-1:0]  win_idx,
  output logic                    busy,
  output logic                    done
);

`ifdef CONV_FEEDER_PAD_EN
  localparam int P = (K - 1) / 2;
  localparam int W = N;
`else
  localparam int P = 0;
  localparam int W = N - K + 1;
`endif

  localparam int IW = $clog2(N + 1);
  localparam int LW = $clog2(N + K + 1);
  localparam int TW = $clog2(K + 1);
  localparam int SW = $clog2(N + K + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t               r_state;
  logic [LW-1:0]        r_ld_cnt;
  logic [IW-1:0]        r_win;
  logic [TW-1:0]        r_tap;
  logic [IW-1:0]        r_vcnt;

  logic signed [DW-1:0] r_wt [K];
  logic signed [DW-1:0] r_fm [N];

  logic                 r_in_ready;
  logic signed [DW-1:0] r_data_fmaps;
  logic signed [DW-1:0] r_data_weight;
  logic                 r_worken;
  logic                 r_outputen;
  logic                 r_acc_valid;
  logic [IW-1:0]        r_win_idx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_ld_last;
  logic                 w_tap_last;
  logic                 w_run_last;
  logic [IW-1:0]        w_nxt_win;
  logic [TW-1:0]        w_nxt_tap;
  logic [SW-1:0]        w_pos;
  logic signed [DW-1:0] w_fm_sel;
  logic signed [DW-1:0] w_wt_sel;

  assign w_accept   = r_in_ready && in_valid;
  assign w_ld_last  = (r_ld_cnt == LW'(N + K - 1));
  assign w_tap_last = (r_tap == TW'(K - 1));
  assign w_run_last = w_tap_last && (r_win == IW'(W - 1));

  // Position of the pair to present next cycle. Outside RUN it is (0,0), which
  // is exactly what the LOAD->RUN edge needs for the first operand pair.
  always_comb begin
    w_nxt_win = '0;
    w_nxt_tap = '0;
    if (r_state == S_RUN) begin
      if (w_tap_last) begin
        w_nxt_tap = '0;
        w_nxt_win = r_win + IW'(1);
      end else begin
        w_nxt_tap = r_tap + TW'(1);
        w_nxt_win = r_win;
      end
    end
  end

  // fmap[i] is selected when w+t == i+P, so padded positions (w+t-P outside
  // 0..N-1) match no entry and fall through to zero. Without padding P=0 and
  // every reachable position matches.
  assign w_pos = SW'(w_nxt_win) + SW'(w_nxt_tap);

  always_comb begin
    w_fm_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pos == SW'(i + P)) w_fm_sel = r_fm[i];
    end
  end

  always_comb begin
    w_wt_sel = '0;
    for (int i = 0; i < K; i++) begin
      if (w_nxt_tap == TW'(i)) w_wt_sel = r_wt[i];
    end
  end

  // Operand buffers are never cleared; they are fully rewritten by every load.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < K; i++) begin
        if (r_ld_cnt == LW'(i)) r_wt[i] <= in_data;
      end
      for (int i = 0; i < N; i++) begin
        if (r_ld_cnt == LW'(K + i)) r_fm[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ld_cnt      <= '0;
      r_win         <= '0;
      r_tap         <= '0;
      r_vcnt        <= '0;
      r_in_ready    <= 1'b0;
      r_data_fmaps  <= '0;
      r_data_weight <= '0;
      r_worken      <= 1'b0;
      r_outputen    <= 1'b0;
      r_acc_valid   <= 1'b0;
      r_win_idx     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // The MAC registers acc on outputen, so its result is valid one cycle later.
      r_acc_valid <= r_outputen;
      if (r_outputen) begin
        r_win_idx <= r_vcnt;
        r_vcnt    <= r_vcnt + IW'(1);
      end else begin
        r_win_idx <= '0;
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= S_LOAD;
            r_ld_cnt   <= '0;
            r_vcnt     <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_ld_cnt <= r_ld_cnt + LW'(1);
            if (w_ld_last) begin
              r_state       <= S_RUN;
              r_in_ready    <= 1'b0;
              r_win         <= '0;
              r_tap         <= '0;
              r_worken      <= 1'b1;
              r_outputen    <= 1'b0;
              r_data_fmaps  <= w_fm_sel;
              r_data_weight <= w_wt_sel;
            end
          end
        end

        S_RUN: begin
          r_worken <= 1'b1;
          if (w_run_last) begin
            // Zero operands with a dump strobe: MAC latches the final window
            // and restarts its partial sum at 0.
            r_state       <= S_FLUSH;
            r_outputen    <= 1'b1;
            r_data_fmaps  <= '0;
            r_data_weight <= '0;
          end else begin
            r_win         <= w_nxt_win;
            r_tap         <= w_nxt_tap;
            // Tap 0 of any window after the first dumps the previous window.
            r_outputen    <= (w_nxt_tap == '0);
            r_data_fmaps  <= w_fm_sel;
            r_data_weight <= w_wt_sel;
          end
        end

        S_FLUSH: begin
          r_state       <= S_DRAIN;
          r_worken      <= 1'b0;
          r_outputen    <= 1'b0;
          r_data_fmaps  <= '0;
          r_data_weight <= '0;
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
        end

        S_DRAIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign data_fmaps  = r_data_fmaps;
  assign data_weight = r_data_weight;
  assign worken      = r_worken;
  assign outputen    = r_outputen;
  assign acc_valid   = r_acc_valid;
  assign win_idx     = r_win_idx;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_conv_feeder.sv
module tb_conv_feeder;

  localparam int K  = 3;
  localparam int N  = 5;
  localparam int DW = 8;
`ifdef CONV_FEEDER_PAD_EN
  localparam int P = (K - 1) / 2;
  localparam int W = N;
`else
  localparam int P = 0;
  localparam int W = N - K + 1;
`endif
  localparam int IW = $clog2(N + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic signed [DW-1:0] data_fmaps;
  logic signed [DW-1:0] data_weight;
  logic                 worken;
  logic                 outputen;
  logic                 acc_valid;
  logic [IW-1:0]        win_idx;
  logic                 busy;
  logic                 done;

  conv_feeder #(.K(K), .N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .data_fmaps (data_fmaps),
    .data_weight(data_weight),
    .worken     (worken),
    .outputen   (outputen),
    .acc_valid  (acc_valid),
    .win_idx    (win_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference data and expected per-window dot products.
  int     wt [K];
  int     fm [N];
  longint expv [W];

  function automatic void compute_exp();
    for (int w = 0; w < W; w++) begin
      longint s = 0;
      for (int t = 0; t < K; t++) begin
        int idx = w + t - P;
        if (idx >= 0 && idx < N) s += longint'(wt[t]) * longint'(fm[idx]);
      end
      expv[w] = s;
    end
  endfunction

  function automatic bit exp_oe(input int c);
    return (c < W * K && c % K == 0 && c >= K) || (c == W * K);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_fmaps"}, data_fmaps, 0);
    chk({tag, "_weight"}, data_weight, 0);
    chk({tag, "_worken"}, worken, 0);
    chk({tag, "_outputen"}, outputen, 0);
    chk({tag, "_acc_valid"}, acc_valid, 0);
    chk({tag, "_win_idx"}, win_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // bubbles: 0 none, 1 alternating, 2 random. start_at / rst_at: RUN cycle or -1.
  task automatic do_run(input int bubbles, input int start_at, input int rst_at);
    int     acc;
    int     cyc;
    int     pulses;
    longint m_tmp;
    longint m_acc;
    longint p;
    compute_exp();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;

    acc = 0;
    cyc = 0;
    while (acc < N + K && cyc < 8 * (N + K)) begin
      case (bubbles)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (in_valid) in_data = DW'(acc < K ? wt[acc] : fm[acc - K]);
      else          in_data = DW'($urandom);
      @(negedge clk);
      chk("load_in_ready", in_ready, 1);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (acc != N + K) begin
      chk("load_timeout", acc, N + K);
      return;
    end
    if (bubbles == 0) chk("load_cycles", cyc, N + K);
    if (bubbles == 1) chk("load_cycles_bub", cyc, 2 * (N + K) - 1);

    // Behavioural MAC: dump partial sum to acc on outputen, restart with the
    // current product; otherwise accumulate while worken.
    m_tmp  = 0;
    m_acc  = 0;
    pulses = 0;
    for (int c = 0; c <= W * K + 2; c++) begin
      @(negedge clk);
      chk("worken", worken, (c <= W * K) ? 1 : 0);
      chk("outputen", outputen, exp_oe(c) ? 1 : 0);
      chk("acc_valid", acc_valid, (c >= 1 && exp_oe(c - 1)) ? 1 : 0);
      chk("done", done, (c == W * K + 1) ? 1 : 0);
      chk("busy", busy, (c <= W * K) ? 1 : 0);
      chk("run_in_ready", in_ready, 0);
      if (c < W * K) begin
        int w   = c / K;
        int t   = c % K;
        int idx = w + t - P;
        chk("fmaps", data_fmaps, (idx >= 0 && idx < N) ? fm[idx] : 0);
        chk("weight", data_weight, wt[t]);
      end else begin
        chk("fmaps_zero", data_fmaps, 0);
        chk("weight_zero", data_weight, 0);
      end
      if (acc_valid) begin
        chk("win_idx", win_idx, pulses);
        if (pulses < W) chk("acc", m_acc, expv[pulses]);
        pulses++;
      end
      p = longint'(data_fmaps) * longint'(data_weight);
      if (outputen) begin
        m_acc = m_tmp;
        m_tmp = p;
      end else if (worken) begin
        m_tmp += p;
      end
      start = (c == start_at);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst = 1'b0;
        return;
      end
    end
    start = 1'b0;
    chk("pulse_count", pulses, W);
  endtask

  task automatic set_scn1();
    for (int i = 0; i < K; i++) wt[i] = i + 1;
    for (int i = 0; i < N; i++) fm[i] = i + 1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Basic data, no bubbles.
    set_scn1();
    do_run(0, -1, -1);

    // Extremes.
    for (int i = 0; i < K; i++) wt[i] = -128;
    for (int i = 0; i < N; i++) fm[i] = -128;
    do_run(0, -1, -1);
    for (int i = 0; i < K; i++) wt[i] = 127;
    do_run(0, -1, -1);

    // Alternating bubbles.
    set_scn1();
    do_run(1, -1, -1);

    // Reset in the middle of RUN, then a clean reload.
    do_run(0, -1, 4);
    do_run(0, -1, -1);

    // start during RUN is ignored; the following run reloads from scratch.
    do_run(0, 2, -1);
    do_run(0, -1, -1);

    // Random data with random bubbles.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < K; i++) wt[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < N; i++) fm[i] = int'($urandom_range(0, 255)) - 128;
      do_run(2, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
